// File: rtl/muller_c_pkg.sv
// Shared constants and the C-element set/clear/hold rule for the muller_c bank.
// Pure declarations: no logic, no latency of its own.
// No flow control; the rule is evaluated combinationally by its users.
package muller_c_pkg;

  localparam int SYNC_MIN = 2;
  localparam int CNT_W    = 8;
  localparam int VEC_W    = 8;

  typedef enum logic [1:0] {
    C_HOLD = 2'd0,
    C_SET  = 2'd1,
    C_CLR  = 2'd2
  } c_act_e;

  // Classify a vector: only bits flagged in valid take part; an empty set holds.
  function automatic c_act_e c_action(input logic [VEC_W-1:0] vec,
                                      input logic [VEC_W-1:0] valid);
    c_act_e act;
    act = C_HOLD;
    if (valid != '0) begin
      if ((vec & valid) == valid) act = C_SET;
      else if ((vec & valid) == '0) act = C_CLR;
    end
    return act;
  endfunction

  // Next C-element state: all ones sets, all zeros clears, anything else holds.
  function automatic logic c_next(input logic cur,
                                  input logic [VEC_W-1:0] vec,
                                  input logic [VEC_W-1:0] valid);
    logic nxt;
    case (c_action(vec, valid))
      C_SET:   nxt = 1'b1;
      C_CLR:   nxt = 1'b0;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/muller_c_cell.sv
// One C-element channel: input synchroniser, per-input inversion, state register, optional counter.
// Latency: SYNC_STAGES+1 clk edges from in_i to c_o; en_i acts at the next edge.
// No backpressure; en_i low freezes state and counter. Counter present with MULLER_C_CNT_EN.
module muller_c_cell
  import muller_c_pkg::*;
#(
  parameter int               INPUTS      = 3,
  parameter logic [INPUTS-1:0] INV_MASK   = '0,
  parameter logic             RESET_VAL   = 1'b0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INPUTS-1:0] in_i,
  input  logic              en_i,
  output logic              c_o
`ifdef MULLER_C_CNT_EN
  ,
  output logic [CNT_W-1:0]  cnt_o
`endif
);

  logic [INPUTS-1:0] r_sync [SYNC_STAGES];
  logic              r_c;
  logic [INPUTS-1:0] w_x;
  logic              w_c_nxt;

  // Synchroniser chain; stages reset to the inversion mask so every effective input starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= INV_MASK;
    end else begin
      r_sync[0] <= in_i;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_x     = r_sync[SYNC_STAGES-1] ^ INV_MASK;
  assign w_c_nxt = en_i ? c_next(r_c, VEC_W'(w_x), VEC_W'({INPUTS{1'b1}})) : r_c;

  // C-element state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_c <= RESET_VAL;
    else        r_c <= w_c_nxt;
  end

  assign c_o = r_c;

`ifdef MULLER_C_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Count every output transition; a disabled channel cannot change state, so it also holds here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_cnt <= '0;
    else if (w_c_nxt != r_c) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign cnt_o = r_cnt;
`endif

endmodule

// File: rtl/muller_c_bank.sv
// Bank of CHANNELS clocked C-elements plus a second-level C-element (done_o) over enabled outputs.
// Latency: in_i to c_o SYNC_STAGES+1 edges, c_o to done_o one more edge.
// No backpressure; four-phase signalling only. Optional counters/cnt_o with MULLER_C_CNT_EN.
module muller_c_bank
  import muller_c_pkg::*;
#(
  parameter int                        CHANNELS    = 4,
  parameter int                        INPUTS      = 3,
  parameter logic [CHANNELS*INPUTS-1:0] INV_MASK   = '0,
  parameter logic                      RESET_VAL   = 1'b0,
  parameter int                        SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHANNELS*INPUTS-1:0] in_i,
  input  logic [CHANNELS-1:0]        en_i,
  output logic [CHANNELS-1:0]        c_o,
  output logic                       done_o
`ifdef MULLER_C_CNT_EN
  ,
  output logic [CHANNELS*CNT_W-1:0]  cnt_o
`endif
);

  // A single synchroniser flop is not metastability-safe; refuse to build.
  if (SYNC_STAGES < SYNC_MIN) begin : g_bad_sync
    $error("muller_c_bank: SYNC_STAGES must be at least SYNC_MIN");
  end

  logic [CHANNELS-1:0] w_c;
  logic                r_done;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_cell
    muller_c_cell #(
      .INPUTS      (INPUTS),
      .INV_MASK    (INV_MASK[k*INPUTS +: INPUTS]),
      .RESET_VAL   (RESET_VAL),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .in_i  (in_i[k*INPUTS +: INPUTS]),
      .en_i  (en_i[k]),
      .c_o   (w_c[k])
`ifdef MULLER_C_CNT_EN
      ,
      .cnt_o (cnt_o[k*CNT_W +: CNT_W])
`endif
    );
  end

  // Completion C-element over enabled channels; with nothing enabled the valid set is empty and it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done <= RESET_VAL;
    else        r_done <= c_next(r_done, VEC_W'(w_c), VEC_W'(en_i));
  end

  assign c_o    = w_c;
  assign done_o = r_done;

endmodule
